timekeeper: RTL
===============

TIMEKEEPER -- requirements
Module: timekeeper

Interface
REQ-001 The block SHALL have parameter CHIME_EN, default 1, meaning 1 enables the hourly chime outputs and 0 ties them low.
REQ-002 clk_100m  input  1  system clock; all logic SHALL be clocked on its rising edge; this is the only clock.
REQ-003 cr  input  1  reset; synchronous and active-high.
REQ-004 clk_1hz  input  1  1 Hz square wave from the clock divider; SHALL be treated as asynchronous to clk_100m.
REQ-005 hold  input  1  level; freezes the time count.
REQ-006 adj_min  input  1  level; minute adjust.
REQ-007 adj_hour  input  1  level; hour adjust.
REQ-008 hour_h  output  2  hours tens digit, BCD 0-2.
REQ-009 hour_l  output  4  hours units digit, BCD 0-9.
REQ-010 min_h  output  3  minutes tens digit, 0-5.
REQ-011 min_l  output  4  minutes units digit, 0-9.
REQ-012 sec_h  output  3  seconds tens digit, 0-5.
REQ-013 sec_l  output  4  seconds units digit, 0-9.
REQ-014 sec_tick  output  1  one-clk_100m-cycle pulse per detected clk_1hz rising edge.
REQ-015 chime_lo  output  1  low-tone chime request.
REQ-016 chime_hi  output  1  high-tone chime request.

Function
REQ-017 clk_1hz SHALL pass through a 2-flop synchronizer followed by a history flop; a rising edge is a synchronized 0 followed by a synchronized 1.
REQ-018 sec_tick SHALL be registered; if edge E is the first clk_100m edge that samples clk_1hz high, sec_tick SHALL be 1 in the cycle after edge E+2 (3-cycle latency) for exactly one cycle.
REQ-019 The digit registers SHALL update on the clk_100m edge at which sec_tick is 1, so they change 4 cycles after edge E; digits SHALL change at no other time except reset.
REQ-020 Priority on a tick: cr > hold > adjust (adj_min/adj_hour) > normal count.
REQ-021 Normal count: sec 00-59; 59 wraps to 00 and carries into minutes; min 59 wraps to 00 and carries into hours; 23:59:59 wraps to 00:00:00 in one tick; hours are 24-hour.
REQ-022 BCD rules: each units digit wraps 9 to 0 and increments its tens digit; hours wrap at 23, never 24; no digit SHALL ever hold a non-BCD or out-of-range value.
REQ-023 hold=1: digits are unchanged on ticks; sec_tick still pulses.
REQ-024 Adjust: on a tick with adj_min=1, minutes increment mod 60 with no carry to hours.
REQ-025 Adjust: on a tick with adj_hour=1, hours increment mod 24.
REQ-026 Adjust: on any adjust tick, seconds are forced to 00; with both adj_min and adj_hour high, both increment in the same tick.
REQ-027 Adjust inputs sampled between ticks SHALL have no effect; adj_min, adj_hour and hold are sampled only on tick cycles.
REQ-028 chime_lo SHALL be 1 while the displayed time is min=59 and sec in {51,53,55,57}; chime_hi SHALL be 1 while min=59 and sec=59.
REQ-029 Both chime outputs SHALL be 0 while hold, adj_min or adj_hour is 1, or when CHIME_EN=0.
REQ-030 The chime outputs SHALL be registered and change 1 cycle after the digit update.

Reset
REQ-031 While cr=1 at a clock edge: all digits 00:00:00; sec_tick=0; chime_lo=chime_hi=0; synchronizer and history flops cleared.
REQ-032 If clk_1hz is already high when cr deasserts, no tick SHALL be generated until clk_1hz has been synchronously seen low and then high again.
REQ-033 Reset asserted mid-count, including in the sec_tick cycle, SHALL win; no increment occurs in that cycle.

Verification
REQ-034 Reset, then 60 clk_1hz rising edges -> 00:01:00; each sec_tick exactly 1 cycle wide, digits change 4 cycles after the first sampling edge.
REQ-035 Preload by ticking to 23:59:58, then 2 ticks -> 23:59:59 then 00:00:00; chime_hi=1 during 23:59:59.
REQ-036 At 10:59:50, 10 ticks -> chime_lo high at :51/:53/:55/:57, low at :52/:54/:56/:58; chime_hi high at :59; all chimes low at 11:00:00.
REQ-037 At 12:59:30 with adj_min=1, 1 tick -> 12:00:00 (no hour carry); adj_hour=1 at 23:xx, 1 tick -> hour 00; both high at 09:05:17 -> 10:06:00.
REQ-038 hold=1 for 5 ticks -> digits unchanged and 5 sec_tick pulses; clk_1hz high at cr release -> no tick until the next 0-to-1 transition.

Source files
------------

// File: rtl/timekeeper.sv
// 24-hour BCD time-of-day counter advanced by a synchronized 1 Hz edge, with hold/adjust and hourly chime.
// sec_tick 3 cycles after the first sampling edge; digits update on the tick edge; chimes 1 cycle later.
module timekeeper #(
  parameter bit CHIME_EN = 1'b1
) (
  input  logic       clk_100m,
  input  logic       cr,
  input  logic       clk_1hz,
  input  logic       hold,
  input  logic       adj_min,
  input  logic       adj_hour,
  output logic [1:0] hour_h,
  output logic [3:0] hour_l,
  output logic [2:0] min_h,
  output logic [3:0] min_l,
  output logic [2:0] sec_h,
  output logic [3:0] sec_l,
  output logic       sec_tick,
  output logic       chime_lo,
  output logic       chime_hi
);

  logic sync_q1, sync_q2, hist_q;
  logic vld_q1, vld_q2, armed_q;

  // armed only after a genuine low has been sampled, so a high input at reset release cannot tick
  always_ff @(posedge clk_100m) begin
    if (cr) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      hist_q   <= 1'b0;
      vld_q1   <= 1'b0;
      vld_q2   <= 1'b0;
      armed_q  <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sync_q1  <= clk_1hz;
      sync_q2  <= sync_q1;
      hist_q   <= sync_q2;
      vld_q1   <= 1'b1;
      vld_q2   <= vld_q1;
      if (vld_q2 && !sync_q2) armed_q <= 1'b1;
      sec_tick <= sync_q2 && !hist_q && armed_q;
    end
  end

  logic       sec_wrap, min_wrap, hour_wrap;
  logic [2:0] sec_inc_h, min_inc_h;
  logic [3:0] sec_inc_l, min_inc_l, hour_inc_l;
  logic [1:0] hour_inc_h;

  always_comb begin
    sec_wrap  = (sec_h == 3'd5) && (sec_l == 4'd9);
    min_wrap  = (min_h == 3'd5) && (min_l == 4'd9);
    hour_wrap = (hour_h == 2'd2) && (hour_l == 4'd3);
    sec_inc_h = sec_h;
    sec_inc_l = sec_l + 4'd1;
    if (sec_wrap) begin
      sec_inc_h = 3'd0;
      sec_inc_l = 4'd0;
    end else if (sec_l == 4'd9) begin
      sec_inc_h = sec_h + 3'd1;
      sec_inc_l = 4'd0;
    end
    min_inc_h = min_h;
    min_inc_l = min_l + 4'd1;
    if (min_wrap) begin
      min_inc_h = 3'd0;
      min_inc_l = 4'd0;
    end else if (min_l == 4'd9) begin
      min_inc_h = min_h + 3'd1;
      min_inc_l = 4'd0;
    end
    hour_inc_h = hour_h;
    hour_inc_l = hour_l + 4'd1;
    if (hour_wrap) begin
      hour_inc_h = 2'd0;
      hour_inc_l = 4'd0;
    end else if (hour_l == 4'd9) begin
      hour_inc_h = hour_h + 2'd1;
      hour_inc_l = 4'd0;
    end
  end

  logic [1:0] hour_h_n;
  logic [3:0] hour_l_n, min_l_n, sec_l_n;
  logic [2:0] min_h_n, sec_h_n;

  always_comb begin
    hour_h_n = hour_h;
    hour_l_n = hour_l;
    min_h_n  = min_h;
    min_l_n  = min_l;
    sec_h_n  = sec_h;
    sec_l_n  = sec_l;
    if (sec_tick && !hold) begin
      if (adj_min || adj_hour) begin
        sec_h_n = 3'd0;
        sec_l_n = 4'd0;
        if (adj_min) begin
          min_h_n = min_inc_h;
          min_l_n = min_inc_l;
        end
        if (adj_hour) begin
          hour_h_n = hour_inc_h;
          hour_l_n = hour_inc_l;
        end
      end else begin
        sec_h_n = sec_inc_h;
        sec_l_n = sec_inc_l;
        if (sec_wrap) begin
          min_h_n = min_inc_h;
          min_l_n = min_inc_l;
          if (min_wrap) begin
            hour_h_n = hour_inc_h;
            hour_l_n = hour_inc_l;
          end
        end
      end
    end
  end

  logic chime_lo_n, chime_hi_n, chime_ok;

  always_comb begin
    chime_ok   = CHIME_EN && !hold && !adj_min && !adj_hour && min_wrap && (sec_h == 3'd5);
    chime_lo_n = chime_ok && ((sec_l == 4'd1) || (sec_l == 4'd3) ||
                              (sec_l == 4'd5) || (sec_l == 4'd7));
    chime_hi_n = chime_ok && (sec_l == 4'd9);
  end

  always_ff @(posedge clk_100m) begin
    if (cr) begin
      hour_h   <= 2'd0;
      hour_l   <= 4'd0;
      min_h    <= 3'd0;
      min_l    <= 4'd0;
      sec_h    <= 3'd0;
      sec_l    <= 4'd0;
      chime_lo <= 1'b0;
      chime_hi <= 1'b0;
    end else begin
      hour_h   <= hour_h_n;
      hour_l   <= hour_l_n;
      min_h    <= min_h_n;
      min_l    <= min_l_n;
      sec_h    <= sec_h_n;
      sec_l    <= sec_l_n;
      chime_lo <= chime_lo_n;
      chime_hi <= chime_hi_n;
    end
  end

endmodule
